// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte producers.
// Round-robin when UART_ARB_RR_EN is defined, fixed priority otherwise.
`ifndef BYTE_SIZE
`define BYTE_SIZE 8
`endif

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = `BYTE_SIZE,
  parameter int BUSY_TO = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      to_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TO + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic          accept;

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept = rst_n && (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  assign tx_start = (state == START);
  assign busy     = (state != IDLE);

`ifdef UART_ARB_RR_EN
  logic [PW-1:0] nxt_ptr;

  assign nxt_ptr = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= nxt_ptr;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_data  <= '0;
      grant_id <= '0;
      to_err   <= 1'b0;
    end else begin
      to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= req_data[win*DATA_W +: DATA_W];
            grant_id <= win;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            if (cnt != CW'(BUSY_TO)) cnt <= cnt + 1'b1;
            if (cnt == CW'(BUSY_TO - 1)) begin
              to_err <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors and corner sequences for
// uart_tx_arbiter with a simple 10-cycle transmitter model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int TO    = 15;
  localparam int FRAME = 10;
  localparam int GAP   = FRAME + 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           busy;
  logic           to_err;

  uart_tx_arbiter #(
    .N_REQ  (N),
    .DATA_W (W),
    .BUSY_TO(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .busy     (busy),
    .to_err   (to_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit model_en = 1'b1;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && model_en) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_start(input string name, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        c = cyc;
        break;
      end
    end
    chk({name, " start"}, {31'd0, tx_start}, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk({name, " idle"}, {31'd0, busy}, 0);
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [1:0] win;
  } vec_t;

  vec_t tab [7];
  logic [7:0] lut [4];
  logic [1:0] s_win [5];

`ifdef UART_ARB_RR_EN
  localparam logic [1:0] W4 = 2'd3;
`else
  localparam logic [1:0] W4 = 2'd0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int prev;
    int te;
    int seen;

    lut = '{8'h10, 8'h21, 8'h32, 8'h43};
`ifdef UART_ARB_RR_EN
    s_win = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    s_win = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    tab[0] = '{4'b0001, 2'd0};
    tab[1] = '{4'b0110, 2'd1};
    tab[2] = '{4'b0011, 2'd0};
    tab[3] = '{4'b1100, 2'd2};
    tab[4] = '{4'b1001, W4};
    tab[5] = '{4'b1010, 2'd1};
    tab[6] = '{4'b0100, 2'd2};

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h4332_2110;

    repeat (3) begin
      @(negedge clk);
      chk("rst ready", req_ready, 0);
      chk("rst start", tx_start, 0);
      chk("rst data", tx_data, 0);
      chk("rst grant", grant_id, 0);
      chk("rst busy", busy, 0);
      chk("rst to_err", to_err, 0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel ready", req_ready, 4'b0001);

    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_start("stream", c);
      if (n == 4) req_valid = '0;
      chk("stream grant", grant_id, s_win[n]);
      chk("stream data", tx_data, lut[s_win[n]]);
      if (n > 0) chk("stream gap", c - prev, GAP);
      prev = c;
    end
    wait_idle("stream");

    foreach (tab[i]) begin
      @(negedge clk);
      req_valid = tab[i].valid;
      #1 chk("vec ready", req_ready, 4'b0001 << tab[i].win);
      wait_start("vec", c);
      req_valid = '0;
      chk("vec grant", grant_id, tab[i].win);
      chk("vec data", tx_data, lut[tab[i].win]);
      wait_idle("vec");
    end

    req_data[31:24] = 8'hA5;
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("wrap ready", req_ready, 4'b1000);
    wait_start("wrap", c);
    req_valid = '0;
    chk("wrap grant", grant_id, 3);
    chk("wrap data", tx_data, 8'hA5);
    wait_idle("wrap");
    @(negedge clk);
    req_valid = 4'hF;
    #1 chk("after wrap ready", req_ready, 4'b0001);
    wait_start("after wrap", c);
    req_valid = '0;
    chk("after wrap grant", grant_id, 0);
    wait_idle("after wrap");

    model_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b0100;
    wait_start("timeout", c);
    req_valid = '0;
    chk("timeout grant", grant_id, 2);
    te = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (to_err === 1'b1) begin
        te = cyc;
        break;
      end
    end
    chk("to_err seen", to_err, 1);
    chk("to_err delay", te - c, TO + 1);
    chk("to_err busy", busy, 0);
    @(negedge clk);
    chk("to_err width", to_err, 0);
    model_en = 1'b1;

    req_valid = 4'b0010;
    wait_start("post to", c);
    req_valid = '0;
    chk("post to grant", grant_id, 1);
    chk("post to data", tx_data, 8'h21);
    wait_idle("post to");

    @(negedge clk);
    req_valid = 4'b0001;
    wait_start("midrst", c);
    repeat (4) @(negedge clk);
    chk("midrst in frame", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst start", tx_start, 0);
    chk("midrst ready", req_ready, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || req_ready !== 4'b0000) seen++;
    end
    chk("midrst quiet", seen, 0);
    rst_n = 1'b1;
    #1 chk("midrst rel ready", req_ready, 4'b0001);
    wait_start("midrst rel", c);
    req_valid = '0;
    chk("midrst grant", grant_id, 0);
    chk("midrst data", tx_data, 8'h10);
    wait_idle("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte producers. It accepts one byte at a time from the winning requester over a valid/ready handshake. It then issues a one-cycle start to the transmitter and holds off further grants until the transmitter reports the frame complete. It sits between the internal producers (loopback path, status reporter, command responder) and the `uart_tx` datapath inside `uart_top`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, `` `BYTE_SIZE ``: byte width.
- `BUSY_TO`, 15: cycles to wait for `tx_busy` to rise after `tx_start` before aborting.

Ports:
- `clk` input 1: system clock, `` `CLK_MHZ ``.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input N_REQ: requester i has a byte.
- `req_data` input N_REQ*DATA_W: byte i occupies bits [i*DATA_W +: DATA_W].
- `req_ready` output N_REQ: one-hot accept; transfer when `req_valid[i] && req_ready[i]`.
- `tx_start` output 1: one-cycle pulse to `uart_tx`.
- `tx_data` output DATA_W: byte for `uart_tx`, stable from `tx_start` until IDLE.
- `tx_busy` input 1: high while `uart_tx` shifts a frame.
- `grant_id` output $clog2(N_REQ): index of the requester owning the current frame.
- `busy` output 1: arbiter not in IDLE.
- `to_err` output 1: one-cycle pulse on `BUSY_TO` abort.

## Operation
- FSM states:
  - IDLE: if any `req_valid`, pick winner, assert its `req_ready` combinationally this cycle, latch `req_data` slice into `tx_data` and index into `grant_id`, go to START.
  - START: `tx_start`=1 for exactly this cycle, go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy`=1 go to WAIT_DONE. After `BUSY_TO` cycles without it, pulse `to_err`, go to IDLE.
  - WAIT_DONE: on `tx_busy`=0 go to IDLE.
- `req_ready` is zero outside IDLE and zero when no `req_valid`. It is never multi-hot.
- Winner selection: first asserted `req_valid` scanning upward from pointer `rr_ptr`, wrapping modulo `N_REQ`.
- `rr_ptr` updates on each accept to (winner+1) mod `N_REQ`. Wrap at `N_REQ-1` returns to 0.
- Timeout counter is `$clog2(BUSY_TO+1)` bits. It clears on entry to WAIT_BUSY and saturates.
- Requester dropping `req_valid` without handshake is legal; no state is held for it.
- `tx_busy` already high in START: ignored. Entry to WAIT_BUSY then sees it next cycle.

## Timing
- Reset values: state=IDLE, `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `busy`=0, `to_err`=0, `rr_ptr`=0.
- `req_valid` seen in IDLE at cycle k:
  - accept at edge k.
  - `tx_start`=1 during cycle k+1.
  - earliest WAIT_DONE at k+3, when `uart_tx` raises `tx_busy` at k+2.
- `tx_busy` falls at cycle m: IDLE at m+1; next accept possible at m+1. Back-to-back byte spacing is therefore frame length + 3 cycles.
- Reset asserted mid-frame: FSM to IDLE immediately. The byte in `uart_tx` is not tracked, and no `req_ready` appears until `rst_n` deasserts.
- `to_err` pulses in the cycle IDLE is entered, with the count reaching `BUSY_TO`.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin as above.
- Not defined: fixed priority, lowest index wins. `rr_ptr` is removed and treated as constant 0. All other behaviour is identical.

## Test plan
- Reset with `req_valid`=4'b1111 held: all outputs 0 until `rst_n` rises. First accept goes to requester 0, with `tx_data`=`req_data[7:0]`.
- All four requesters valid continuously, bytes 8'h10/8'h21/8'h32/8'h43; transmitter model busy for 10 frame cycles. Required: grants 0,1,2,3,0 in order, `tx_start` spaced by frame length + 3, no lost bytes. Without `UART_ARB_RR_EN`: requester 0 only.
- Requester 3 only, `rr_ptr`=3, byte 8'hA5. Required: accept, `tx_data`=8'hA5, `grant_id`=3, then `rr_ptr` wraps to 0.
- Transmitter never raises `tx_busy`. Required: `to_err` pulse exactly `BUSY_TO`=15 cycles after WAIT_BUSY entry, return to IDLE, next request served normally.
- `rst_n` pulsed low during WAIT_DONE. Required: `busy`=0 immediately, `tx_start` stays 0. After release, the pending request is accepted within 1 cycle.
- End-to-end in `tb_uart`: loopback through `uart_top` with 2 requesters sending 8'h55 and 8'hAA. Required: the monitor sees 55, AA, 55, AA with no parity error.
